// File: rtl/conv_encoder_tx.sv
// Framed K=3 rate-1/2 convolutional encoder (G0=111, G1=101) with zero tail,
// antipodal soft-symbol mapping and optional Galois-LFSR noise injection.
module conv_encoder_tx #(
    parameter int          N          = 32,
    parameter bit          TAIL_EN    = 1'b1,
    parameter logic [15:0] NOISE_SEED = 16'hACE1,
    parameter int          FC_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                noise_en,
    output logic [1:0]          out_p,
    output logic [7:0]          out_sym0,
    output logic [7:0]          out_sym1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [FC_WIDTH-1:0] frame_cnt,
    output logic                busy
);
    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic {S_DATA, S_TAIL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic          tail_cnt, tail_cnt_nxt;
    logic [1:0]    enc, enc_nxt;      // {s1,s0}
    logic [15:0]   lfsr, lfsr_nxt;
    logic          slot_free, load, u, last_beat, p0, p1;

    // Saturating add of a 5-bit signed noise sample to the +127/-128 base.
    function automatic logic [7:0] map_sym(input logic b, input logic [4:0] n5, input logic en);
        logic signed [8:0] base, noise, sum;
        base  = b ? 9'sd127 : -9'sd128;
        noise = en ? {{4{n5[4]}}, n5} : 9'sd0;
        sum   = base + noise;
        if (sum > 9'sd127)
            return 8'h7F;
        else if (sum < -9'sd128)
            return 8'h80;
        else
            return sum[7:0];
    endfunction

    always_comb begin
        slot_free    = !out_valid || out_ready;
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tail_cnt_nxt = tail_cnt;
        enc_nxt      = enc;
        in_ready     = 1'b0;
        load         = 1'b0;
        u            = 1'b0;
        last_beat    = 1'b0;
        case (state)
            S_DATA: begin
                in_ready = slot_free && !rst;
                load     = in_valid && in_ready;
                u        = in_bit;
                if (load) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        if (TAIL_EN) begin
                            state_nxt = S_TAIL;
                            enc_nxt   = {u, enc[1]};
                        end else begin
                            // No tail: trellis is forced back to 00 for the next frame.
                            enc_nxt   = 2'b00;
                            last_beat = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        enc_nxt     = {u, enc[1]};
                    end
                end
            end
            S_TAIL: begin
                load = slot_free;
                if (load) begin
                    enc_nxt = {1'b0, enc[1]};
                    if (tail_cnt) begin
                        tail_cnt_nxt = 1'b0;
                        state_nxt    = S_DATA;
                        last_beat    = 1'b1;
                    end else begin
                        tail_cnt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_DATA;
        endcase
        p0       = u ^ enc[1] ^ enc[0];
        p1       = u ^ enc[0];
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DATA;
            bit_cnt   <= '0;
            tail_cnt  <= 1'b0;
            enc       <= 2'b00;
            lfsr      <= NOISE_SEED;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_p     <= 2'b00;
            out_sym0  <= 8'h00;
            out_sym1  <= 8'h00;
            frame_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tail_cnt <= tail_cnt_nxt;
            enc      <= enc_nxt;
            if (load) begin
                // Noise uses the pre-advance LFSR value.
                out_valid <= 1'b1;
                out_p     <= {p0, p1};
                out_sym0  <= map_sym(p0, lfsr[4:0], noise_en);
                out_sym1  <= map_sym(p1, lfsr[12:8], noise_en);
                out_last  <= last_beat;
                if (last_beat)
                    frame_cnt <= frame_cnt + 1'b1;
                if (noise_en)
                    lfsr <= lfsr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (bit_cnt != '0) || (state == S_TAIL) || out_valid;

endmodule
